// File: rtl/ram_pkg.sv
// Shared definitions for the RAM built-in self-test: default geometry,
// sequencer states and the address-derived test pattern.
package ram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Only the low data-width bits of the address take part in the pattern.
  function automatic logic [RAM_DATA_W-1:0] expected(input logic [RAM_DATA_W-1:0] seed,
                                                      input logic [RAM_DATA_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Port bundle between the self-test sequencer and the synchronous RAM.
interface ram_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Din;
  logic              EN;
  logic              WE;
  logic [DATA_W-1:0] RamDOut;

  modport master (output Addr, Din, EN, WE, input RamDOut);
  modport slave  (input Addr, Din, EN, WE, output RamDOut);
endinterface

// File: rtl/ram_bist_checker.sv
// Read-back compare pipeline: holds the expectation for the read in flight,
// counts mismatches (saturating) and latches the first failing address.
module ram_bist_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [7:0]        err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              clean_d_o
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] pend_exp_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [7:0]        err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              first_q, first_d;
  logic              mismatch;

  always_comb begin
    pend_v_d = load_i;
    err_d    = err_q;
    fail_d   = fail_q;
    first_d  = first_q;
    mismatch = pend_v_q && (rdata_i != pend_exp_q);
    if (clear_i) begin
      err_d   = '0;
      fail_d  = '0;
      first_d = 1'b0;
    end else if (mismatch) begin
      err_d = sat_inc(err_q);
      if (!first_q) begin
        fail_d  = pend_addr_q;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_v_q <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
    end
  end

  // RAM data arrives one cycle after the read is issued; park its expectation.
  always_ff @(posedge CLK) begin
    if (load_i) begin
      pend_exp_q  <= exp_i;
      pend_addr_q <= addr_i;
    end
  end

  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_q;
  assign clean_d_o   = (err_d == 8'd0);

endmodule

// File: rtl/ram_bist.sv
// RAM self-test sequencer: writes seed^addr to every location, reads it all
// back through the checker and reports pass/fail with error statistics.
module ram_bist
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Start,
  input  logic [DATA_W-1:0] Seed,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [7:0]        ErrCount,
  output logic [ADDR_W-1:0] FailAddr,
  ram_bist_if.master        ram
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    return DATA_W'(expected(RAM_DATA_W'(s), RAM_DATA_W'(a)));
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              en_q, en_d, we_q, we_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              start_acc;
  logic              clean_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    seed_d    = seed_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    pass_d    = pass_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          start_acc = 1'b1;
          seed_d    = Seed;
          state_d   = WR;
          addr_d    = '0;
          din_d     = pat(Seed, '0);
          en_d      = 1'b1;
          we_d      = 1'b1;
          pass_d    = 1'b0;
        end
      end
      WR: begin
        en_d = 1'b1;
        if (addr_q == LAST) begin
          state_d = RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          din_d  = pat(seed_q, addr_q + 1'b1);
          we_d   = 1'b1;
        end
      end
      RD: begin
        if (addr_q == LAST) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          en_d   = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        pass_d  = clean_d;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WR) || (state_d == RD) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      seed_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      seed_q  <= seed_d;
      en_q    <= en_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  ram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .clear_i     (start_acc),
    .load_i      (state_q == RD),
    .exp_i       (pat(seed_q, addr_q)),
    .addr_i      (addr_q),
    .rdata_i     (ram.RamDOut),
    .err_cnt_o   (ErrCount),
    .fail_addr_o (FailAddr),
    .clean_d_o   (clean_d)
  );

  assign ram.Addr = addr_q;
  assign ram.Din  = din_q;
  assign ram.EN   = en_q;
  assign ram.WE   = we_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with behavioural RAMs that can inject faults.
module tb_ram_bist;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       Start, Start2;
  logic [7:0] Seed;
  logic       Busy, Done, Pass;
  logic [7:0] ErrCount;
  logic [7:0] FailAddr;
  logic       Busy2, Done2, Pass2;
  logic [7:0] ErrCount2;
  logic [8:0] FailAddr2;

  int total = 0;
  int bad = 0;
  int fault_mode = 0;
  int cnt;

  always #5 CLK = ~CLK;

  ram_bist_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  ram_bist_if #(.ADDR_W(9), .DATA_W(8)) bus2 ();

  ram_bist u_dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Seed(Seed),
    .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount),
    .FailAddr(FailAddr), .ram(bus)
  );

  ram_bist #(.ADDR_W(9), .DATA_W(8), .DEPTH(256)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .Start(Start2), .Seed(Seed),
    .Busy(Busy2), .Done(Done2), .Pass(Pass2), .ErrCount(ErrCount2),
    .FailAddr(FailAddr2), .ram(bus2)
  );

  // 128x8 RAM: mode 1 sticks bit 3 of location 0x10 high, mode 2 inverts reads
  logic [7:0] mem [128];
  logic [7:0] rd;
  always @(posedge CLK) begin
    if (bus.EN) begin
      if (bus.WE) mem[bus.Addr[6:0]] <= bus.Din;
      else begin
        rd = mem[bus.Addr[6:0]];
        if (fault_mode == 1 && bus.Addr == 8'h10) rd = rd | 8'h08;
        if (fault_mode == 2) rd = ~rd;
        bus.RamDOut <= rd;
      end
    end
  end

  // 256x8 RAM that always inverts reads
  logic [7:0] mem2 [256];
  always @(posedge CLK) begin
    if (bus2.EN) begin
      if (bus2.WE) mem2[bus2.Addr[7:0]] <= bus2.Din;
      else bus2.RamDOut <= ~mem2[bus2.Addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic run_test(input logic [7:0] seed, input bit poke,
                          input logic [7:0] exp_err, input logic [7:0] exp_fail,
                          input logic exp_pass);
    Seed = seed;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Seed = ~seed;
    chk("start_busy", Busy, 1);
    chk("start_done", Done, 0);
    chk("wr0_bus", {bus.EN, bus.WE, bus.Addr, bus.Din}, {1'b1, 1'b1, 8'h00, seed});
    for (int k = 1; k < 257; k++) begin
      Start = poke && (k == 50 || k == 200);
      Seed = seed ^ 8'h5A ^ 8'(k);
      tick();
      Start = 1'b0;
      chk("run_busy", {Busy, Done}, 2'b10);
      chk("addr_msb", bus.Addr[7], 0);
      if (k < 128) begin
        chk("wr_bus", {bus.EN, bus.WE, bus.Addr}, {1'b1, 1'b1, 8'(k)});
        chk("wr_din", bus.Din, seed ^ 8'(k));
      end else if (k < 256) begin
        chk("rd_bus", {bus.EN, bus.WE, bus.Addr}, {1'b1, 1'b0, 8'(k - 128)});
      end else begin
        chk("drain_bus", {bus.EN, bus.WE, bus.Addr}, {1'b0, 1'b0, 8'h00});
      end
    end
    tick();
    chk("done_flags", {Done, Busy, bus.EN}, 3'b100);
    chk("done_pass", Pass, exp_pass);
    chk("done_err", ErrCount, exp_err);
    chk("done_fail", FailAddr, exp_fail);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem2[i] = 8'h00;
    RST_N = 1'b0;
    Start = 1'b1;
    Start2 = 1'b0;
    Seed = 8'h5A;
    repeat (3) tick();
    chk("rst_status", {Busy, Done, Pass}, 3'b000);
    chk("rst_err", ErrCount, 0);
    chk("rst_fail", FailAddr, 0);
    chk("rst_bus", {bus.Addr, bus.Din, bus.EN, bus.WE}, 18'h0);

    RST_N = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_en", {bus.EN, Busy}, 2'b00);
    end

    fault_mode = 0;
    run_test(8'hA5, 1'b0, 8'd0, 8'h00, 1'b1);
    fault_mode = 1;
    run_test(8'h00, 1'b0, 8'd1, 8'h10, 1'b0);
    fault_mode = 2;
    run_test(8'h3C, 1'b0, 8'd128, 8'h00, 1'b0);
    fault_mode = 0;
    run_test(8'hC3, 1'b1, 8'd0, 8'h00, 1'b1);

    // Start held high: restart from DONE on the very next edge
    Seed = 8'h11;
    Start = 1'b1;
    tick();
    wait_done(cnt);
    chk("held_latency", cnt, 257);
    Seed = 8'h22;
    tick();
    chk("held_restart", {Done, Busy, bus.WE, bus.Addr}, {1'b0, 1'b1, 1'b1, 8'h00});
    chk("held_din", bus.Din, 8'h22);
    Start = 1'b0;
    wait_done(cnt);
    chk("held_latency2", cnt, 257);
    chk("held_pass", Pass, 1);

    // Reset in the read phase after 11 inverted compares
    fault_mode = 2;
    Seed = 8'h77;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (140) tick();
    chk("pre_rst_err", ErrCount, 11);
    RST_N = 1'b0;
    tick();
    chk("mid_rst_bus", {bus.EN, bus.WE, Busy, bus.Addr}, 11'h0);
    chk("mid_rst_err", ErrCount, 0);
    RST_N = 1'b1;
    fault_mode = 0;
    tick();
    chk("post_rst_idle", {bus.EN, Busy, Done}, 3'b000);
    run_test(8'h5E, 1'b0, 8'd0, 8'h00, 1'b1);

    // 256-deep variant with every read inverted saturates the counter
    Seed = 8'h00;
    Start2 = 1'b1;
    tick();
    Start2 = 1'b0;
    cnt = 0;
    while (!Done2 && cnt < 700) begin
      tick();
      cnt++;
      chk("d2_addr_msb", bus2.Addr[8], 0);
    end
    chk("d2_latency", cnt, 513);
    chk("d2_err", ErrCount2, 255);
    chk("d2_fail", FailAddr2, 0);
    chk("d2_pass", Pass2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
